// File: rtl/hk_regbank_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hk_regbank_arbiter_if                                           |
// | Purpose  : Bundles the SPI strobe port, management bus handshake and       |
// |            register-bank access signals of hk_regbank_arbiter.             |
// |            Signal prefixes (i_/o_) are from the arbiter's point of view.   |
// | Modports : slave  - the arbiter itself                                     |
// |            master - the environment (SPI slave, mgmt bridge, reg bank)     |
// | Signals  : i_spi_wrstb/i_spi_rdstb  SPI strobes (SCK domain)               |
// |            i_spi_addr/i_spi_wdata   SPI address / write data               |
// |            o_spi_rdata/o_spi_overrun SPI read data / sticky drop flag      |
// |            i_mgmt_req/we/addr/wdata management request                     |
// |            o_mgmt_ack/o_mgmt_rdata  management completion / read data      |
// |            o_rb_en/we/addr/wdata    register bank access                   |
// |            i_rb_rdata               register bank read data                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface hk_regbank_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          i_spi_wrstb;
  logic          i_spi_rdstb;
  logic [AW-1:0] i_spi_addr;
  logic [DW-1:0] i_spi_wdata;
  logic [DW-1:0] o_spi_rdata;
  logic          o_spi_overrun;
  logic          i_mgmt_req;
  logic          i_mgmt_we;
  logic [AW-1:0] i_mgmt_addr;
  logic [DW-1:0] i_mgmt_wdata;
  logic          o_mgmt_ack;
  logic [DW-1:0] o_mgmt_rdata;
  logic          o_rb_en;
  logic          o_rb_we;
  logic [AW-1:0] o_rb_addr;
  logic [DW-1:0] o_rb_wdata;
  logic [DW-1:0] i_rb_rdata;

  modport slave (
    input  i_spi_wrstb, i_spi_rdstb, i_spi_addr, i_spi_wdata,
    output o_spi_rdata, o_spi_overrun,
    input  i_mgmt_req, i_mgmt_we, i_mgmt_addr, i_mgmt_wdata,
    output o_mgmt_ack, o_mgmt_rdata,
    output o_rb_en, o_rb_we, o_rb_addr, o_rb_wdata,
    input  i_rb_rdata
  );

  modport master (
    output i_spi_wrstb, i_spi_rdstb, i_spi_addr, i_spi_wdata,
    input  o_spi_rdata, o_spi_overrun,
    output i_mgmt_req, i_mgmt_we, i_mgmt_addr, i_mgmt_wdata,
    input  o_mgmt_ack, o_mgmt_rdata,
    input  o_rb_en, o_rb_we, o_rb_addr, o_rb_wdata,
    output i_rb_rdata
  );
endinterface
`default_nettype wire

// File: rtl/hk_regbank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hk_regbank_arbiter                                              |
// | Purpose  : Shares one single-port housekeeping register bank between the   |
// |            SPI slave port and the management CPU port. SPI strobes are     |
// |            synchronised into clk; one access is granted at a time and the  |
// |            read data is returned to the granted requester.                 |
// | Ports    : clk        system clock                                         |
// |            csb_reset  asynchronous active-high reset                       |
// |            bus        hk_regbank_arbiter_if.slave (SPI, mgmt, bank)        |
// | Config   : HK_ARB_ROUND_ROBIN_EN - when defined, conflicts are resolved    |
// |            round-robin; otherwise SPI has fixed priority.                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hk_regbank_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input wire                  clk,
  input wire                  csb_reset,
  hk_regbank_arbiter_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

  // SPI strobe synchronisers and edge detectors
  logic [1:0]    r_wr_sync;
  logic [1:0]    r_rd_sync;
  logic          r_wr_dly;
  logic          r_rd_dly;
  logic          w_wr_edge;
  logic          w_rd_edge;
  logic          w_spi_edge;

  // Captured SPI request
  logic          r_spi_pend;
  logic          r_spi_pwe;
  logic [AW-1:0] r_spi_addr;
  logic [DW-1:0] r_spi_wdata;
  logic          r_spi_overrun;
  logic [DW-1:0] r_spi_rdata;

  // Arbitration / access
  logic [1:0]    r_state;
  logic          r_win_spi;
  logic          r_rb_we;
  logic [AW-1:0] r_rb_addr;
  logic [DW-1:0] r_rb_wdata;
  logic          r_mgmt_ack;
  logic [DW-1:0] r_mgmt_rdata;

  logic          w_mgmt_pend;
  logic          w_grant_valid;
  logic          w_grant_spi;
  logic          w_spi_done;

  assign w_wr_edge  = r_wr_sync[1] & ~r_wr_dly;
  assign w_rd_edge  = r_rd_sync[1] & ~r_rd_dly;
  assign w_spi_edge = w_wr_edge | w_rd_edge;

  // The requester holds req until the cycle after ack, so ignore it while
  // ack is high to avoid granting the same request twice.
  assign w_mgmt_pend   = bus.i_mgmt_req & ~r_mgmt_ack;
  assign w_grant_valid = (r_state == c_ST_IDLE) & (r_spi_pend | w_mgmt_pend);
  assign w_spi_done    = (r_state == c_ST_RESP) & r_win_spi;

`ifdef HK_ARB_ROUND_ROBIN_EN
  // 1 = SPI received the most recent grant
  logic r_last_spi;

  always_ff @(posedge clk or posedge csb_reset) begin
    if (csb_reset) begin
      r_last_spi <= 1'b0;
    end else if (w_grant_valid) begin
      r_last_spi <= w_grant_spi;
    end
  end

  assign w_grant_spi = r_spi_pend & (~w_mgmt_pend | ~r_last_spi);
`else
  assign w_grant_spi = r_spi_pend;
`endif

  // Strobe synchronisation: rise -> sync[0] -> sync[1] (edge seen) -> pend
  always_ff @(posedge clk or posedge csb_reset) begin
    if (csb_reset) begin
      r_wr_sync <= 2'b00;
      r_rd_sync <= 2'b00;
      r_wr_dly  <= 1'b0;
      r_rd_dly  <= 1'b0;
    end else begin
      r_wr_sync <= {r_wr_sync[0], bus.i_spi_wrstb};
      r_rd_sync <= {r_rd_sync[0], bus.i_spi_rdstb};
      r_wr_dly  <= r_wr_sync[1];
      r_rd_dly  <= r_rd_sync[1];
    end
  end

  // SPI request capture. Completion clears the flag; an edge arriving while a
  // request is still outstanding (including its completing cycle) is dropped.
  always_ff @(posedge clk or posedge csb_reset) begin
    if (csb_reset) begin
      r_spi_pend    <= 1'b0;
      r_spi_pwe     <= 1'b0;
      r_spi_addr    <= '0;
      r_spi_wdata   <= '0;
      r_spi_overrun <= 1'b0;
    end else begin
      if (w_spi_done) begin
        r_spi_pend <= 1'b0;
      end
      if (w_spi_edge) begin
        if (r_spi_pend) begin
          r_spi_overrun <= 1'b1;
        end else begin
          r_spi_pend  <= 1'b1;
          // Simultaneous read and write edges collapse into one write
          r_spi_pwe   <= w_wr_edge;
          r_spi_addr  <= bus.i_spi_addr;
          r_spi_wdata <= bus.i_spi_wdata;
        end
      end
    end
  end

  // Access state machine
  always_ff @(posedge clk or posedge csb_reset) begin
    if (csb_reset) begin
      r_state      <= c_ST_IDLE;
      r_win_spi    <= 1'b0;
      r_rb_we      <= 1'b0;
      r_rb_addr    <= '0;
      r_rb_wdata   <= '0;
      r_mgmt_ack   <= 1'b0;
      r_mgmt_rdata <= '0;
      r_spi_rdata  <= '0;
    end else begin
      r_mgmt_ack <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_grant_valid) begin
            r_state   <= c_ST_ACCESS;
            r_win_spi <= w_grant_spi;
            if (w_grant_spi) begin
              r_rb_we    <= r_spi_pwe;
              r_rb_addr  <= r_spi_addr;
              r_rb_wdata <= r_spi_wdata;
            end else begin
              r_rb_we    <= bus.i_mgmt_we;
              r_rb_addr  <= bus.i_mgmt_addr;
              r_rb_wdata <= bus.i_mgmt_wdata;
            end
          end
        end
        c_ST_ACCESS: begin
          r_state <= c_ST_RESP;
        end
        c_ST_RESP: begin
          // Bank data is valid in this cycle, one clock after rb_en
          r_state <= c_ST_IDLE;
          if (r_win_spi) begin
            if (!r_rb_we) begin
              r_spi_rdata <= bus.i_rb_rdata;
            end
          end else begin
            r_mgmt_rdata <= bus.i_rb_rdata;
            r_mgmt_ack   <= 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Decoded from state so that reset removes the enable immediately
  assign bus.o_rb_en       = (r_state == c_ST_ACCESS);
  assign bus.o_rb_we       = r_rb_we;
  assign bus.o_rb_addr     = r_rb_addr;
  assign bus.o_rb_wdata    = r_rb_wdata;
  assign bus.o_spi_rdata   = r_spi_rdata;
  assign bus.o_spi_overrun = r_spi_overrun;
  assign bus.o_mgmt_ack    = r_mgmt_ack;
  assign bus.o_mgmt_rdata  = r_mgmt_rdata;

endmodule
`default_nettype wire

// File: tb/tb_hk_regbank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hk_regbank_arbiter                                           |
// | Purpose  : Directed self-checking bench for hk_regbank_arbiter with a      |
// |            simple register-bank model and an access log.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_hk_regbank_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic csb_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hk_regbank_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  hk_regbank_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .csb_reset (csb_reset),
    .bus       (bus)
  );

  // Register bank model: read data registered one clock after rb_en
  logic [7:0] mem [256];
  logic       preload = 1'b1;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h22) ? 8'h3C : 8'h00;
      preload <= 1'b0;
    end else if (bus.o_rb_en) begin
      if (bus.o_rb_we) mem[bus.o_rb_addr] <= bus.o_rb_wdata;
      bus.i_rb_rdata <= mem[bus.o_rb_addr];
    end
  end

  // Access log and ack / back-to-back counters
  logic [7:0] log_addr [$];
  logic       log_we   [$];
  logic [7:0] log_wd   [$];
  int         ack_cnt = 0;
  int         en_dbl  = 0;
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    if (bus.o_rb_en) begin
      log_addr.push_back(bus.o_rb_addr);
      log_we.push_back(bus.o_rb_we);
      log_wd.push_back(bus.o_rb_wdata);
      if (prev_en) en_dbl++;
    end
    if (bus.o_mgmt_ack) ack_cnt++;
    prev_en = bus.o_rb_en;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_access(input logic wr, input logic rd, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.i_spi_addr  = a;
    bus.i_spi_wdata = d;
    bus.i_spi_wrstb = wr;
    bus.i_spi_rdstb = rd;
    repeat (6) @(posedge clk); #1;
    bus.i_spi_wrstb = 1'b0;
    bus.i_spi_rdstb = 1'b0;
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic mgmt_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output int seen);
    @(posedge clk); #1;
    bus.i_mgmt_req   = 1'b1;
    bus.i_mgmt_we    = we;
    bus.i_mgmt_addr  = a;
    bus.i_mgmt_wdata = d;
    seen = 0;
    rd   = 8'h00;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.o_mgmt_ack) begin
        seen = 1;
        rd   = bus.o_mgmt_rdata;
      end
    end
    @(posedge clk); #1;
    bus.i_mgmt_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int         base;
    int         k;
    int         seen;
    int         acks0;
    logic [7:0] rd;

    csb_reset        = 1'b1;
    bus.i_spi_wrstb  = 1'b0;
    bus.i_spi_rdstb  = 1'b0;
    bus.i_spi_addr   = 8'h00;
    bus.i_spi_wdata  = 8'h00;
    bus.i_mgmt_req   = 1'b0;
    bus.i_mgmt_we    = 1'b0;
    bus.i_mgmt_addr  = 8'h00;
    bus.i_mgmt_wdata = 8'h00;
    repeat (3) @(posedge clk); #1;
    csb_reset = 1'b0;

    // Reset state
    check_eq("rst_rb_en",     bus.o_rb_en,        0);
    check_eq("rst_rb_we",     bus.o_rb_we,        0);
    check_eq("rst_rb_addr",   bus.o_rb_addr,      0);
    check_eq("rst_rb_wdata",  bus.o_rb_wdata,     0);
    check_eq("rst_spi_rdata", bus.o_spi_rdata,    0);
    check_eq("rst_overrun",   bus.o_spi_overrun,  0);
    check_eq("rst_ack",       bus.o_mgmt_ack,     0);
    check_eq("rst_mgmt_rd",   bus.o_mgmt_rdata,   0);

    // T1: management write 0x10 <= 0xA5, latency N -> N+1 -> N+3
    @(posedge clk); #1;
    bus.i_mgmt_req   = 1'b1;
    bus.i_mgmt_we    = 1'b1;
    bus.i_mgmt_addr  = 8'h10;
    bus.i_mgmt_wdata = 8'hA5;
    @(negedge clk);
    check_eq("t1_en_cycN", bus.o_rb_en, 0);
    @(negedge clk);
    check_eq("t1_en",    bus.o_rb_en,    1);
    check_eq("t1_we",    bus.o_rb_we,    1);
    check_eq("t1_addr",  bus.o_rb_addr,  8'h10);
    check_eq("t1_wdata", bus.o_rb_wdata, 8'hA5);
    @(negedge clk);
    check_eq("t1_ack_n2", bus.o_mgmt_ack, 0);
    check_eq("t1_en_off", bus.o_rb_en,    0);
    @(negedge clk);
    check_eq("t1_ack_n3", bus.o_mgmt_ack, 1);
    @(posedge clk); #1;
    bus.i_mgmt_req = 1'b0;
    @(negedge clk);
    check_eq("t1_ack_pulse", bus.o_mgmt_ack, 0);
    @(posedge clk); #1;
    check_eq("t1_mem",     mem[8'h10], 8'hA5);
    check_eq("t1_ack_cnt", ack_cnt,    1);

    // T2: SPI read of 0x22 (bank holds 0x3C)
    acks0 = ack_cnt;
    @(posedge clk); #1;
    bus.i_spi_addr  = 8'h22;
    bus.i_spi_rdstb = 1'b1;
    k    = 0;
    seen = 0;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(negedge clk);
      k++;
      if (bus.o_rb_en) seen = 1;
    end
    check_eq("t2_en_lat", k,             5);
    check_eq("t2_addr",   bus.o_rb_addr, 8'h22);
    check_eq("t2_we",     bus.o_rb_we,   0);
    @(posedge clk); #1;
    check_eq("t2_rdata_early", bus.o_spi_rdata, 8'h00);
    @(posedge clk); #1;
    check_eq("t2_spi_rdata",   bus.o_spi_rdata, 8'h3C);
    bus.i_spi_rdstb = 1'b0;
    repeat (4) @(posedge clk); #1;
    check_eq("t2_no_ack", ack_cnt, acks0);

    // T3: SPI write 0x30 and mgmt read 0x10 pending in the same IDLE cycle
    base = log_addr.size();
    @(posedge clk); #1;
    bus.i_spi_addr  = 8'h30;
    bus.i_spi_wdata = 8'h77;
    bus.i_spi_wrstb = 1'b1;
    repeat (3) @(posedge clk); #1;
    bus.i_mgmt_req  = 1'b1;
    bus.i_mgmt_we   = 1'b0;
    bus.i_mgmt_addr = 8'h10;
    seen = 0;
    rd   = 8'h00;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.o_mgmt_ack) begin
        seen = 1;
        rd   = bus.o_mgmt_rdata;
      end
    end
    @(posedge clk); #1;
    bus.i_mgmt_req  = 1'b0;
    bus.i_spi_wrstb = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_eq("t3_ack_seen",  seen, 1);
    check_eq("t3_mgmt_rd",   rd,   8'hA5);
    check_eq("t3_n_access",  log_addr.size(), base + 2);
`ifdef HK_ARB_ROUND_ROBIN_EN
    check_eq("t3_first_addr",  log_addr[base],     8'h10);
    check_eq("t3_first_we",    log_we[base],       0);
    check_eq("t3_second_addr", log_addr[base + 1], 8'h30);
    check_eq("t3_second_we",   log_we[base + 1],   1);
`else
    check_eq("t3_first_addr",  log_addr[base],     8'h30);
    check_eq("t3_first_we",    log_we[base],       1);
    check_eq("t3_second_addr", log_addr[base + 1], 8'h10);
    check_eq("t3_second_we",   log_we[base + 1],   0);
`endif
    check_eq("t3_mem30",     mem[8'h30],      8'h77);
    check_eq("t3_spi_rdata", bus.o_spi_rdata, 8'h3C);

    // T4: second SPI write edge while the first is still pending
    acks0 = ack_cnt;
    base  = log_addr.size();
    @(posedge clk); #1;
    bus.i_spi_addr   = 8'h50;
    bus.i_spi_wdata  = 8'h99;
    bus.i_spi_wrstb  = 1'b1;
    @(posedge clk); #1;
    bus.i_spi_wrstb  = 1'b0;
    bus.i_mgmt_req   = 1'b1;
    bus.i_mgmt_we    = 1'b1;
    bus.i_mgmt_addr  = 8'h40;
    bus.i_mgmt_wdata = 8'h11;
    @(posedge clk); #1;
    bus.i_spi_wrstb  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_spi_addr   = 8'h51;
    bus.i_spi_wdata  = 8'hEE;
    @(posedge clk); #1;
    bus.i_mgmt_req   = 1'b0;
    @(posedge clk); #1;
    bus.i_spi_wrstb  = 1'b0;
    repeat (8) @(posedge clk); #1;
    check_eq("t4_ack_cnt",   ack_cnt,         acks0 + 1);
    check_eq("t4_n_access",  log_addr.size(), base + 2);
    check_eq("t4_mgmt_addr", log_addr[base],     8'h40);
    check_eq("t4_spi_addr",  log_addr[base + 1], 8'h50);
    check_eq("t4_spi_wd",    log_wd[base + 1],   8'h99);
    check_eq("t4_mem40",     mem[8'h40], 8'h11);
    check_eq("t4_mem50",     mem[8'h50], 8'h99);
    check_eq("t4_mem51",     mem[8'h51], 8'h00);
    check_eq("t4_overrun",   bus.o_spi_overrun, 1);
    spi_access(1'b1, 1'b0, 8'h52, 8'h01);
    check_eq("t4_mem52",        mem[8'h52], 8'h01);
    check_eq("t4_ovr_sticky",   bus.o_spi_overrun, 1);

    // T5: reset asserted during ACCESS
    acks0 = ack_cnt;
    @(posedge clk); #1;
    bus.i_mgmt_req   = 1'b1;
    bus.i_mgmt_we    = 1'b1;
    bus.i_mgmt_addr  = 8'h60;
    bus.i_mgmt_wdata = 8'h42;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_in_access", bus.o_rb_en, 1);
    #1;
    csb_reset      = 1'b1;
    bus.i_mgmt_req = 1'b0;
    #1;
    check_eq("t5_rb_en",     bus.o_rb_en,       0);
    check_eq("t5_rb_we",     bus.o_rb_we,       0);
    check_eq("t5_rb_addr",   bus.o_rb_addr,     0);
    check_eq("t5_rb_wdata",  bus.o_rb_wdata,    0);
    check_eq("t5_overrun",   bus.o_spi_overrun, 0);
    check_eq("t5_spi_rdata", bus.o_spi_rdata,   0);
    check_eq("t5_mgmt_rd",   bus.o_mgmt_rdata,  0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    csb_reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    check_eq("t5_no_ack", ack_cnt,    acks0);
    check_eq("t5_mem60",  mem[8'h60], 8'h00);
    mgmt_xfer(1'b1, 8'h61, 8'h5A, rd, seen);
    check_eq("t5_wr_ack", seen, 1);
    mgmt_xfer(1'b0, 8'h61, 8'h00, rd, seen);
    check_eq("t5_rd_ack", seen, 1);
    check_eq("t5_rd_data", rd, 8'h5A);

    // T6: simultaneous read and write strobes act as one write
    spi_access(1'b0, 1'b1, 8'h22, 8'h00);
    check_eq("t6_pre_rdata", bus.o_spi_rdata, 8'h3C);
    base = log_addr.size();
    spi_access(1'b1, 1'b1, 8'h70, 8'h33);
    check_eq("t6_n_access", log_addr.size(), base + 1);
    check_eq("t6_we",       log_we[base],    1);
    check_eq("t6_addr",     log_addr[base],  8'h70);
    check_eq("t6_mem70",    mem[8'h70],      8'h33);
    check_eq("t6_rdata",    bus.o_spi_rdata, 8'h3C);

    check_eq("rb_en_b2b", en_dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hk_regbank_arbiter.md
Name: hk_regbank_arbiter

Overview:
- Shares one single-port housekeeping register bank between two requesters: the SPI slave port and the management CPU port.
- SPI strobes arrive asynchronously from the SCK domain and are synchronised into clk.
- Grants one access at a time and returns read data to the requester that was granted.
- Sits between the SPI slave, the management bus bridge and the register bank.

Parameters:
- AW, 8, address width
- DW, 8, data width

Ports:
- clk  input  1  system clock
- csb_reset  input  1  reset, asynchronous, active-high
- spi_wrstb  input  1  SPI write strobe, SCK domain
- spi_rdstb  input  1  SPI read strobe, SCK domain
- spi_addr  input  AW  SPI address; stable for ≥4 clk after either strobe rises
- spi_wdata  input  DW  SPI write data; stable for ≥4 clk after spi_wrstb rises
- spi_rdata  output  DW  read data returned to SPI; held until next SPI read completes
- spi_overrun  output  1  sticky: an SPI strobe was dropped
- mgmt_req  input  1  management request, level
- mgmt_we  input  1  1 = write
- mgmt_addr  input  AW  management address
- mgmt_wdata  input  DW  management write data
- mgmt_ack  output  1  one-cycle completion pulse
- mgmt_rdata  output  DW  management read data, valid while mgmt_ack is high
- rb_en  output  1  register bank access enable
- rb_we  output  1  register bank write enable
- rb_addr  output  AW  register bank address
- rb_wdata  output  DW  register bank write data
- rb_rdata  input  DW  bank read data, valid one clk after rb_en

Behaviour:
- Reset (async on csb_reset):
  - state = IDLE.
  - All outputs 0: spi_rdata, spi_overrun, mgmt_ack, mgmt_rdata, rb_*.
  - Synchronisers, pending flags and last_grant cleared.
- SPI synchronisation:
  - Each strobe passes through a 2-flop synchroniser, then a rising-edge detector.
  - On a detected edge, spi_addr/spi_wdata are captured and spi_pend is set, with spi_pwe = 1 for wrstb and 0 for rdstb.
  - Strobe rise to spi_pend is 3 clk edges.
  - Both edges in the same cycle: treated as one write request.
  - Edge while spi_pend is already set: new request dropped, spi_overrun set (sticky until reset).
- Management handshake:
  - mgmt_req is sampled only in IDLE, and only while mgmt_ack is low.
  - The requester holds req/we/addr/wdata stable until ack and drops req in the cycle after ack.
- FSM, states IDLE, ACCESS, RESP:
  - IDLE: if any request is pending, pick the winner, register rb_addr/rb_we/rb_wdata, go to ACCESS.
  - ACCESS: rb_en = 1 for exactly this cycle; go to RESP.
  - RESP: rb_rdata sampled at the end of the cycle.
    - SPI winner: reads update spi_rdata, writes leave it unchanged; spi_pend cleared.
    - Mgmt winner: mgmt_rdata loaded; mgmt_ack = 1 in the following cycle.
    - Go to IDLE.
  - Mgmt latency: req seen in IDLE cycle N → rb_en in N+1 → mgmt_ack in N+3. Back-to-back grants are possible from N+3.
- Arbitration on conflict (both pending in IDLE): SPI wins. See Optional Feature.
- rb_en is never high in two consecutive cycles, and never outside ACCESS.
- Clock ratio: clk ≥ 16× SCK, which guarantees spi_rdata settles before the next SCK falling edge.
- Reset asserted mid-transaction aborts immediately:
  - no ack is issued;
  - the pending SPI request is lost;
  - rb_en deasserts asynchronously.

Optional Feature:
- Macro: HK_ARB_ROUND_ROBIN_EN.
- Defined:
  - On conflict, grant the requester that was not granted last; last_grant is updated on every grant.
  - A requester never waits more than one other access.
- Undefined:
  - Fixed priority, SPI always wins.
  - last_grant logic absent.

Test Plan:
- Mgmt write addr 0x10 data 0xA5, no SPI traffic → rb_en=1, rb_we=1, rb_addr=0x10, rb_wdata=0xA5 one cycle after req; mgmt_ack pulses exactly 3 cycles after req sampled.
- Bank returns 0x3C for addr 0x22; SPI rdstb with spi_addr=0x22 → rb_en 4–5 clk after the strobe; spi_rdata = 0x3C 2 clk later; mgmt_ack stays 0.
- SPI write and mgmt read pending in the same IDLE cycle:
  - Without the macro: SPI granted first, then mgmt.
  - With HK_ARB_ROUND_ROBIN_EN and last_grant = SPI: mgmt granted first.
- Second SPI wrstb edge while the first is still pending (mgmt occupying the bank) → second dropped, spi_overrun = 1 and stays 1; the first write completes with its original data.
- csb_reset pulsed while in ACCESS → rb_en drops at once, outputs all 0; no mgmt_ack; a fresh mgmt request afterwards completes normally.
- Simultaneous spi_rdstb and spi_wrstb rise → exactly one bank access with rb_we=1; spi_rdata unchanged.
